// File: rtl/mem_access_ctrl.sv
// Single-port data memory access controller: loads, full stores and
// byte-masked stores. Partial stores read the word first and write back the merge.
module mem_access_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  input  logic [MEM_WIDTH-1:0]    req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    mem_we,
  output logic [MEM_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic [DATA_WIDTH-1:0]   mem_dout
);

  localparam int BE_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_we, w_we_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic [BE_W-1:0]       r_be, w_be_nxt;
  logic                  r_req_ready;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic [MEM_WIDTH-1:0]  r_mem_addr, w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0] r_mem_din, w_mem_din_nxt;
  logic [DATA_WIDTH-1:0] w_merged;

  always_comb begin
    w_merged = '0;
    for (int unsigned i = 0; i < BE_W; i++) begin
      w_merged[8*i +: 8] = r_be[i] ? r_wdata[8*i +: 8] : mem_dout[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_we_nxt        = r_we;
    w_be_nxt        = r_be;
    w_wdata_nxt     = r_wdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_din_nxt   = r_mem_din;
    case (r_state)
      IDLE: begin
        if (r_req_ready && req_valid) begin
          w_we_nxt    = req_we;
          w_be_nxt    = req_be;
          w_wdata_nxt = req_wdata;
          if (!req_we) begin
            w_state_nxt    = RD;
            w_mem_addr_nxt = req_addr;
          end else if (&req_be) begin
            w_state_nxt    = WR;
            w_mem_we_nxt   = 1'b1;
            w_mem_addr_nxt = req_addr;
            w_mem_din_nxt  = req_wdata;
          end else if (req_be == '0) begin
            // Empty mask: pass through WR without a write, reporting zero
            w_state_nxt = WR;
            w_wdata_nxt = '0;
          end else begin
            w_state_nxt    = RD;
            w_mem_addr_nxt = req_addr;
          end
        end
      end
      RD: w_state_nxt = CAP;
      CAP: begin
        if (r_we) begin
          w_state_nxt   = WR;
          w_mem_we_nxt  = 1'b1;
          w_mem_din_nxt = w_merged;
          w_wdata_nxt   = w_merged;
        end else begin
          w_state_nxt     = RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = mem_dout;
        end
      end
      WR: begin
        w_state_nxt     = RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_rdata_nxt = r_wdata;
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = IDLE;
          w_rsp_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
    end else begin
      r_we        <= w_we_nxt;
      r_be        <= w_be_nxt;
      r_wdata     <= w_wdata_nxt;
      r_req_ready <= (w_state_nxt == IDLE);
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_din   <= w_mem_din_nxt;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_din   = r_mem_din;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl attached to a registered-output memory model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [1:0]  req_be;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_rdata;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_din, mem_dout;

  logic [15:0] mem [256];
  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  logic [7:0]  we_addr;
  logic [15:0] we_din;
  int          we_base;

  mem_access_ctrl #(.DATA_WIDTH(16), .MEM_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din;
      we_cnt  = we_cnt + 1;
      we_addr = mem_addr;
      we_din  = mem_din;
    end
    mem_dout <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] be, input logic [7:0] addr,
                       input logic [15:0] wdata);
    @(negedge clk);
    chk("req_ready_before_accept", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_be = ~be; req_addr = ~addr; req_wdata = ~wdata;
    chk("req_ready_after_accept", req_ready, 1'b0);
  endtask

  // Called at the negedge just after the accept edge N; response expected after edge N+lat.
  task automatic expect_rsp(input string tag, input int lat, input logic [15:0] exp);
    for (int j = 1; j < lat; j++) begin
      @(negedge clk);
      chk({tag, "_early"}, rsp_valid, 1'b0);
    end
    if (lat > 1) begin end
    if (lat == 1) chk({tag, "_early"}, rsp_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_valid"}, rsp_valid, 1'b1);
    chk({tag, "_rdata"}, rsp_rdata, exp);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", rsp_valid, 1'b0);
    chk("req_ready_after_hs", req_ready, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_be = 2'b00;
    req_addr = 8'h00; req_wdata = 16'h0000; rsp_ready = 1'b0;

    #3;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 16'h0000);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_mem_din", mem_din, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    chk("req_ready_held_low", req_ready, 1'b0);
    @(posedge clk); #1;
    chk("req_ready_first_edge", req_ready, 1'b1);

    // Full store
    we_base = we_cnt;
    issue(1'b1, 2'b11, 8'h10, 16'hA5A5);
    chk("full_st_we_pulse", mem_we, 1'b1);
    chk("full_st_addr", mem_addr, 8'h10);
    chk("full_st_din", mem_din, 16'hA5A5);
    expect_rsp("full_st", 1, 16'hA5A5);
    chk("full_st_we_low", mem_we, 1'b0);
    handshake();
    chk("full_st_we_count", we_cnt - we_base, 1);

    // Load
    we_base = we_cnt;
    issue(1'b0, 2'b00, 8'h10, 16'h0000);
    chk("ld_addr", mem_addr, 8'h10);
    expect_rsp("ld", 2, 16'hA5A5);
    handshake();
    chk("ld_we_count", we_cnt - we_base, 0);

    // Partial store, low byte
    we_base = we_cnt;
    issue(1'b1, 2'b01, 8'h10, 16'h003C);
    chk("part_st_no_we_rd", mem_we, 1'b0);
    @(negedge clk);
    chk("part_st_no_we_cap", mem_we, 1'b0);
    @(negedge clk);
    chk("part_st_we_wr", mem_we, 1'b1);
    chk("part_st_din", mem_din, 16'hA53C);
    @(negedge clk);
    chk("part_st_valid", rsp_valid, 1'b1);
    chk("part_st_rdata", rsp_rdata, 16'hA53C);
    handshake();
    chk("part_st_we_count", we_cnt - we_base, 1);
    chk("part_st_we_addr", we_addr, 8'h10);
    issue(1'b0, 2'b00, 8'h10, 16'h0000);
    expect_rsp("ld_after_part", 2, 16'hA53C);
    handshake();

    // Backpressure at top address, with a competing request
    we_base = we_cnt;
    issue(1'b1, 2'b11, 8'hFF, 16'h1234);
    expect_rsp("bp_st", 1, 16'h1234);
    req_valid = 1'b1; req_we = 1'b1; req_be = 2'b11; req_addr = 8'h20; req_wdata = 16'hDEAD;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_rdata", rsp_rdata, 16'h1234);
      chk("bp_req_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    handshake();
    chk("bp_we_count", we_cnt - we_base, 1);
    chk("bp_we_addr", we_addr, 8'hFF);
    chk("bp_no_stray_store", mem[8'h20], 16'h0000);
    issue(1'b0, 2'b00, 8'hFF, 16'h0000);
    expect_rsp("ld_top", 2, 16'h1234);
    handshake();

    // Partial store, high byte, at address zero
    issue(1'b1, 2'b10, 8'h00, 16'hBB77);
    expect_rsp("part_hi_st", 3, 16'hBB00);
    handshake();
    issue(1'b0, 2'b00, 8'h00, 16'h0000);
    expect_rsp("ld_zero", 2, 16'hBB00);
    handshake();

    // Reset during CAP of a partial store
    we_base = we_cnt;
    issue(1'b1, 2'b10, 8'h10, 16'h7700);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_req_ready", req_ready, 1'b0);
    chk("abort_rsp_valid", rsp_valid, 1'b0);
    chk("abort_mem_we", mem_we, 1'b0);
    chk("abort_mem_addr", mem_addr, 8'h00);
    chk("abort_mem_din", mem_din, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_req_ready_release", req_ready, 1'b1);
    chk("abort_rsp_valid_release", rsp_valid, 1'b0);
    chk("abort_we_count", we_cnt - we_base, 0);
    issue(1'b0, 2'b00, 8'h10, 16'h0000);
    expect_rsp("ld_after_abort", 2, 16'hA53C);
    handshake();

    // Empty byte mask
    we_base = we_cnt;
    issue(1'b1, 2'b00, 8'h10, 16'hFFFF);
    chk("be0_no_we", mem_we, 1'b0);
    expect_rsp("be0", 1, 16'h0000);
    handshake();
    chk("be0_we_count", we_cnt - we_base, 0);
    issue(1'b0, 2'b00, 8'h10, 16'h0000);
    expect_rsp("ld_after_be0", 2, 16'hA53C);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
